// File: rtl/step_counter.sv
// Up-counter with programmable start value, step and terminal bound.
// The carry fires on the enabled step that would pass the bound.
module step_counter #(
  parameter int width       = 8,
  parameter int reset_value = 0,
  parameter int increment   = 1,
  parameter int max_value   = (2**width) - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [width-1:0] count,
  output logic             carry
);

  localparam int SW = 33;
  localparam logic [width-1:0] RV = width'(reset_value);
  localparam logic [SW-1:0] INC = SW'(increment);
  localparam logic [SW-1:0] MAX = SW'(max_value);

  if (width < 1 || width > 31) begin : g_bad_width
    $error("step_counter: width must be 1..31");
  end
  if (increment < 1) begin : g_bad_inc
    $error("step_counter: increment must be >= 1");
  end
  if (max_value < 0 || max_value > (2**width) - 1) begin : g_bad_max
    $error("step_counter: max_value out of range");
  end
  if (reset_value < 0 || reset_value > max_value) begin : g_bad_rv
    $error("step_counter: reset_value must be <= max_value");
  end

  logic [width-1:0] count_q;
  logic [width-1:0] count_d;
  logic [SW-1:0]    sum;
  logic             wrap;

  // Sum is kept wide so a step past the top of the count range
  // is still seen as exceeding the bound.
  always_comb begin
    sum     = {{(SW-width){1'b0}}, count_q} + INC;
    wrap    = sum > MAX;
    count_d = count_q;
    if (enable) begin
      if (wrap) count_d = RV;
      else      count_d = sum[width-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= RV;
    else        count_q <= count_d;
  end

  assign count = count_q;
  assign carry = enable & wrap;

endmodule

// File: tb/tb_step_counter.sv
// Randomised self-checking bench for step_counter.
// Two instances: (4,1,3,15) and the exact-bound case (4,0,5,15).
module tb_step_counter;

  logic       clk = 1'b0;
  logic       rst_a = 1'b1;
  logic       rst_b = 1'b1;
  logic       en_a = 1'b0;
  logic       en_b = 1'b0;
  logic [3:0] count_a;
  logic [3:0] count_b;
  logic       carry_a;
  logic       carry_b;

  int n_cmp = 0;
  int n_bad = 0;
  int m_a = 0;
  int m_b = 0;

  always #5 clk = ~clk;

  step_counter #(
    .width(4), .reset_value(1), .increment(3), .max_value(15)
  ) dut_a (
    .clk(clk), .reset(rst_a), .enable(en_a),
    .count(count_a), .carry(carry_a)
  );

  step_counter #(
    .width(4), .reset_value(0), .increment(5), .max_value(15)
  ) dut_b (
    .clk(clk), .reset(rst_b), .enable(en_b),
    .count(count_b), .carry(carry_b)
  );

  // Reference: the counting rule stated as plain integer arithmetic.
  function automatic bit wraps(int c, int inc, int mx);
    return (c + inc) > mx;
  endfunction

  function automatic int nxt(int c, int inc, int rv, int mx, bit e);
    if (!e) return c;
    if (wraps(c, inc, mx)) return rv;
    return c + inc;
  endfunction

  // Advance one clock; model updates from the enables in force.
  task automatic edge_both();
    @(posedge clk);
    m_a = nxt(m_a, 3, 1, 15, en_a);
    m_b = nxt(m_b, 5, 0, 15, en_b);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    en_a = 0; en_b = 0;
    rst_a = 0; rst_b = 0;
    #2;
    m_a = 1; m_b = 0;
    n_cmp++;
    if (count_a !== 4'(m_a)) begin
      n_bad++;
      $display("FAIL reset_a count=%0d want=%0d", count_a, m_a);
    end
    n_cmp++;
    if (carry_a !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_a carry=%0b want=0", carry_a);
    end
    n_cmp++;
    if (count_b !== 4'(m_b)) begin
      n_bad++;
      $display("FAIL reset_b count=%0d want=%0d", count_b, m_b);
    end
    @(negedge clk);
    rst_a = 1; rst_b = 1;
    #1;
    n_cmp++;
    if (count_a !== 4'd1 || carry_a !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_rel count=%0d carry=%0b want=1/0",
               count_a, carry_a);
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 10; i++) begin
      en_a = 0;
      #1;
      n_cmp++;
      if (carry_a !== 1'b0) begin
        n_bad++;
        $display("FAIL hold carry=%0b want=0 i=%0d", carry_a, i);
      end
      edge_both();
      n_cmp++;
      if (count_a !== 4'd1) begin
        n_bad++;
        $display("FAIL hold count=%0d want=1 i=%0d", count_a, i);
      end
    end
  endtask

  task automatic test_step_wrap();
    int wraps_seen = 0;
    for (int i = 0; i < 22; i++) begin
      en_a = 1;
      #1;
      n_cmp++;
      if (carry_a !== wraps(m_a, 3, 15)) begin
        n_bad++;
        $display("FAIL step carry=%0b want=%0b cnt=%0d",
                 carry_a, wraps(m_a, 3, 15), m_a);
      end
      n_cmp++;
      if (carry_a !== (count_a == 4'd13)) begin
        n_bad++;
        $display("FAIL step carry_at13 carry=%0b count=%0d",
                 carry_a, count_a);
      end
      if (wraps(m_a, 3, 15)) wraps_seen++;
      edge_both();
      n_cmp++;
      if (count_a !== 4'(m_a)) begin
        n_bad++;
        $display("FAIL step count=%0d want=%0d", count_a, m_a);
      end
    end
    n_cmp++;
    if (wraps_seen < 4) begin
      n_bad++;
      $display("FAIL step periods got=%0d want>=4", wraps_seen);
    end
  endtask

  task automatic test_stop();
    int guard = 0;
    // Run until count sits at 13 (wrap pending), then stop.
    while (m_a != 13 && guard < 10) begin
      en_a = 1;
      edge_both();
      guard++;
    end
    for (int i = 0; i < 10; i++) begin
      en_a = 0;
      #1;
      n_cmp++;
      if (carry_a !== 1'b0 || count_a !== 4'd13) begin
        n_bad++;
        $display("FAIL stop13 count=%0d carry=%0b want=13/0",
                 count_a, carry_a);
      end
      edge_both();
    end
    en_a = 1;
    #1;
    n_cmp++;
    if (carry_a !== 1'b1) begin
      n_bad++;
      $display("FAIL stop_wrap carry=%0b want=1", carry_a);
    end
    edge_both();
    for (int i = 0; i < 10; i++) begin
      en_a = 0;
      #1;
      n_cmp++;
      if (carry_a !== 1'b0 || count_a !== 4'd1) begin
        n_bad++;
        $display("FAIL stop1 count=%0d carry=%0b want=1/0",
                 count_a, carry_a);
      end
      edge_both();
    end
  endtask

  task automatic test_async_reset();
    int guard = 0;
    while (m_a != 10 && guard < 10) begin
      en_a = 1;
      edge_both();
      guard++;
    end
    n_cmp++;
    if (count_a !== 4'd10) begin
      n_bad++;
      $display("FAIL arst_pre count=%0d want=10", count_a);
    end
    #2;
    rst_a = 0;
    #1;
    m_a = 1;
    n_cmp++;
    if (count_a !== 4'd1) begin
      n_bad++;
      $display("FAIL arst_now count=%0d want=1", count_a);
    end
    @(posedge clk);
    @(negedge clk);
    rst_a = 1;
    for (int i = 0; i < 4; i++) begin
      en_a = 1;
      edge_both();
      n_cmp++;
      if (count_a !== 4'(m_a)) begin
        n_bad++;
        $display("FAIL arst_resume count=%0d want=%0d", count_a, m_a);
      end
    end
    en_a = 0;
  endtask

  task automatic test_exact_bound();
    int  exp_seq [5] = '{0, 5, 10, 15, 0};
    bit  saw15 = 0;
    for (int i = 0; i < 5; i++) begin
      en_b = 1;
      #1;
      n_cmp++;
      if (count_b !== 4'(exp_seq[i])) begin
        n_bad++;
        $display("FAIL exact count=%0d want=%0d", count_b, exp_seq[i]);
      end
      n_cmp++;
      if (carry_b !== (exp_seq[i] == 15)) begin
        n_bad++;
        $display("FAIL exact carry=%0b at=%0d", carry_b, exp_seq[i]);
      end
      if (count_b == 4'd15) saw15 = 1;
      if (i < 4) edge_both();
    end
    n_cmp++;
    if (!saw15) begin
      n_bad++;
      $display("FAIL exact reached15 got=0 want=1");
    end
    en_b = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      en_a = 1'($urandom);
      en_b = 1'($urandom);
      #1;
      n_cmp++;
      if (carry_a !== (en_a && wraps(m_a, 3, 15)) ||
          carry_b !== (en_b && wraps(m_b, 5, 15))) begin
        n_bad++;
        $display("FAIL rand carry a=%0b b=%0b ma=%0d mb=%0d",
                 carry_a, carry_b, m_a, m_b);
      end
      if ($urandom_range(0, 19) == 0) begin
        rst_a = 0;
        #1;
        m_a = 1;
        n_cmp++;
        if (count_a !== 4'd1) begin
          n_bad++;
          $display("FAIL rand_arst count=%0d want=1", count_a);
        end
        @(posedge clk);
        @(negedge clk);
        rst_a = 1;
        m_b = nxt(m_b, 5, 0, 15, en_b);
      end else begin
        edge_both();
      end
      n_cmp++;
      if (count_a !== 4'(m_a) || count_b !== 4'(m_b)) begin
        n_bad++;
        $display("FAIL rand count a=%0d/%0d b=%0d/%0d",
                 count_a, m_a, count_b, m_b);
      end
    end
    en_a = 0; en_b = 0;
  endtask

  initial begin
    test_reset();
    test_hold();
    test_step_wrap();
    test_stop();
    test_async_reset();
    test_exact_bound();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
